// File: rtl/ccw_output_pkg.sv
// Shared constants, VC state encoding and the hop-field update for the ccw output port.
// Combinational helpers only; no latency or flow control of its own.
package ccw_output_pkg;

  localparam int DATA_WIDTH = 64;
  localparam int HOP_MSB    = 55;
  localparam int HOP_LSB    = 48;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    GRANT = 2'b01,
    FULL  = 2'b10
  } vc_state_e;

  typedef enum logic {
    SRC_CCW = 1'b0,
    SRC_PE  = 1'b1
  } src_e;

  // Each router consumes one hop bit by shifting the field right.
  function automatic logic [DATA_WIDTH-1:0] hop_shift(input logic [DATA_WIDTH-1:0] pkt);
    logic [DATA_WIDTH-1:0] res;
    res = pkt;
    res[HOP_MSB:HOP_LSB] = pkt[HOP_MSB:HOP_LSB] >> 1;
    return res;
  endfunction

endpackage

// File: rtl/ccw_output_vc.sv
// One VC slot: round-robin grant, single-packet buffer, phase-gated launch request.
// Grant 1 cycle after request, buffer 1 cycle later; holds FULL while ccwro is low.
module ccw_output_vc
  import ccw_output_pkg::*;
#(
  parameter bit VC_ODD = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  ccwro,
  input  logic                  request_ccw,
  input  logic                  request_pe,
  input  logic [DATA_WIDTH-1:0] data_in_ccw,
  input  logic [DATA_WIDTH-1:0] data_in_pe,
  output logic                  grant_ccw,
  output logic                  grant_pe,
  output logic                  send_req,
  output logic [DATA_WIDTH-1:0] pkt
);

  vc_state_e             state_q, state_d;
  src_e                  ptr_q, ptr_d;
  src_e                  src_q, src_d;
  logic [DATA_WIDTH-1:0] buf_q, buf_d;
  logic                  grant_ccw_q, grant_ccw_d;
  logic                  grant_pe_q, grant_pe_d;
  logic                  launch;
  src_e                  win;

  // Launch one phase early so ccwso lands in the receiver's phase for this VC.
  assign launch = (state_q == FULL) && ccwro && (polarity != VC_ODD);

  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    src_d       = src_q;
    buf_d       = buf_q;
    grant_ccw_d = 1'b0;
    grant_pe_d  = 1'b0;
    win         = SRC_CCW;
    case (state_q)
      EMPTY: begin
        if (request_ccw && request_pe) begin
          win = ptr_q;
        end else if (request_pe) begin
          win = SRC_PE;
        end else begin
          win = SRC_CCW;
        end
        if (request_ccw || request_pe) begin
          src_d       = win;
          ptr_d       = (win == SRC_CCW) ? SRC_PE : SRC_CCW;
          grant_ccw_d = (win == SRC_CCW);
          grant_pe_d  = (win == SRC_PE);
          state_d     = GRANT;
        end
      end
      GRANT: begin
        buf_d   = (src_q == SRC_PE) ? data_in_pe : data_in_ccw;
        state_d = FULL;
      end
      FULL: begin
        if (launch) begin
          state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= EMPTY;
      ptr_q       <= SRC_CCW;
      src_q       <= SRC_CCW;
      buf_q       <= '0;
      grant_ccw_q <= 1'b0;
      grant_pe_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      src_q       <= src_d;
      buf_q       <= buf_d;
      grant_ccw_q <= grant_ccw_d;
      grant_pe_q  <= grant_pe_d;
    end
  end

  assign grant_ccw = grant_ccw_q;
  assign grant_pe  = grant_pe_q;
  assign send_req  = launch;
  assign pkt       = hop_shift(buf_q);

endmodule

// File: rtl/ccw_output.sv
// Counter-clockwise ring output: even/odd VC slots feeding one registered ccwso/ccwdo port.
// ccwso 1-2 cycles after FULL depending on phase; ccwro low stalls the VC in FULL.
module ccw_output
  import ccw_output_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  polarity,
  input  logic                  request_ccw_even,
  input  logic                  request_ccw_odd,
  input  logic                  request_pe_even,
  input  logic                  request_pe_odd,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_even,
  input  logic [DATA_WIDTH-1:0] data_in_ccw_odd,
  input  logic [DATA_WIDTH-1:0] data_in_pe_even,
  input  logic [DATA_WIDTH-1:0] data_in_pe_odd,
  output logic                  grant_ccw_even,
  output logic                  grant_ccw_odd,
  output logic                  grant_pe_even,
  output logic                  grant_pe_odd,
  output logic                  ccwso,
  input  logic                  ccwro,
  output logic [DATA_WIDTH-1:0] ccwdo
);

  logic                  send_req_even, send_req_odd;
  logic [DATA_WIDTH-1:0] pkt_even, pkt_odd;
  logic                  ccwso_q, ccwso_d;
  logic [DATA_WIDTH-1:0] ccwdo_q, ccwdo_d;

  ccw_output_vc #(.VC_ODD(1'b0)) u_vc_even (
    .clk         (clk),
    .rst         (rst),
    .polarity    (polarity),
    .ccwro       (ccwro),
    .request_ccw (request_ccw_even),
    .request_pe  (request_pe_even),
    .data_in_ccw (data_in_ccw_even),
    .data_in_pe  (data_in_pe_even),
    .grant_ccw   (grant_ccw_even),
    .grant_pe    (grant_pe_even),
    .send_req    (send_req_even),
    .pkt         (pkt_even)
  );

  ccw_output_vc #(.VC_ODD(1'b1)) u_vc_odd (
    .clk         (clk),
    .rst         (rst),
    .polarity    (polarity),
    .ccwro       (ccwro),
    .request_ccw (request_ccw_odd),
    .request_pe  (request_pe_odd),
    .data_in_ccw (data_in_ccw_odd),
    .data_in_pe  (data_in_pe_odd),
    .grant_ccw   (grant_ccw_odd),
    .grant_pe    (grant_pe_odd),
    .send_req    (send_req_odd),
    .pkt         (pkt_odd)
  );

  // Launch phases are disjoint, so at most one send_req is high per cycle.
  always_comb begin
    ccwso_d = send_req_even | send_req_odd;
    ccwdo_d = ccwdo_q;
    if (send_req_odd) begin
      ccwdo_d = pkt_odd;
    end else if (send_req_even) begin
      ccwdo_d = pkt_even;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ccwso_q <= 1'b0;
      ccwdo_q <= '0;
    end else begin
      ccwso_q <= ccwso_d;
      ccwdo_q <= ccwdo_d;
    end
  end

  assign ccwso = ccwso_q;
  assign ccwdo = ccwdo_q;

endmodule
